atten_serial_rx: RTL and testbench

- Receive end of the attenuator 3-wire serial interface (serial clock, serial data, latch enable).
- Samples an external master's 8-bit word in the i_clk domain, LSB first, and latches it on the rising edge of latch enable.
- Presents the word with a one-cycle valid strobe and flags malformed frames.
- Used as an on-chip attenuator model for loopback verification and as a control-bus sniffer on boards with an external controller.

---
 rtl/atten_serial_rx.sv | 147 ++++++++++++++
 tb/tb_atten_serial_rx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atten_serial_rx.sv
// Receive end of the attenuator 3-wire serial link: samples an LSB-first word, latches on LE rise.
// Optional readback shift-out (o_sdo) when ATTEN_RX_READBACK_EN is defined.

module atten_serial_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic lvl,
  output logic rise
);
  logic [2:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '0;
    else     ff <= {ff[1:0], d};
  end

  assign lvl  = ff[1];
  assign rise = ff[1] & ~ff[2];
endmodule

module atten_serial_rx #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_ser_clk,
  input  logic                  i_ser_data,
  input  logic                  i_le,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_frame_err,
  output logic                  o_busy,
  output logic [CNT_WIDTH-1:0]  o_good_count
`ifdef ATTEN_RX_READBACK_EN
  ,
  output logic                  o_sdo
`endif
);
  localparam int NUM_IN = 3;
  localparam int BCW    = $clog2(DATA_WIDTH + 2);
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FULL, OVER} state_t;

  state_t                state;
  logic [BCW-1:0]        bit_cnt;
  logic [TW-1:0]         idle_cnt;
  logic [DATA_WIDTH-1:0] shreg;

  logic [NUM_IN-1:0] raw, lvl, rise;
  logic              clk_acc, le_rise, ser_bit;
  logic [1:0]        unused_sync;

  // lane 0: serial clock, lane 1: serial data, lane 2: latch enable
  assign raw = {i_le, i_ser_data, i_ser_clk};

  for (genvar g = 0; g < NUM_IN; g++) begin : g_sync
    atten_serial_rx_sync u_sync (
      .clk  (i_clk),
      .rst  (i_reset),
      .d    (raw[g]),
      .lvl  (lvl[g]),
      .rise (rise[g])
    );
  end

  assign unused_sync = {lvl[0], rise[1]};
  assign ser_bit     = lvl[1];
  assign le_rise     = rise[2];
  // LE high (including its rising cycle) masks serial-clock edges
  assign clk_acc     = rise[0] & ~lvl[2];
  assign o_busy      = (state != IDLE);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      idle_cnt     <= '0;
      shreg        <= '0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_good_count <= '0;
    end else begin
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      if (le_rise) begin
        if (state == FULL) begin
          o_data       <= shreg;
          o_valid      <= 1'b1;
          o_good_count <= o_good_count + CNT_WIDTH'(1);
        end else begin
          o_frame_err  <= 1'b1;
        end
        state    <= IDLE;
        bit_cnt  <= '0;
        idle_cnt <= '0;
      end else if (clk_acc) begin
        idle_cnt <= '0;
        case (state)
          IDLE: begin
            shreg   <= {ser_bit, shreg[DATA_WIDTH-1:1]};
            bit_cnt <= BCW'(1);
            state   <= SHIFT;
          end
          SHIFT: begin
            shreg   <= {ser_bit, shreg[DATA_WIDTH-1:1]};
            bit_cnt <= bit_cnt + BCW'(1);
            if (bit_cnt == BCW'(DATA_WIDTH - 1)) state <= FULL;
          end
          FULL: begin
            bit_cnt <= BCW'(DATA_WIDTH + 1);
            state   <= OVER;
          end
          default: ;
        endcase
      end else if (state != IDLE) begin
        if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          o_frame_err <= 1'b1;
          state       <= IDLE;
          bit_cnt     <= '0;
          idle_cnt    <= '0;
        end else begin
          idle_cnt <= idle_cnt + TW'(1);
        end
      end
    end
  end

`ifdef ATTEN_RX_READBACK_EN
  logic [DATA_WIDTH-1:0] rb;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rb    <= '0;
      o_sdo <= 1'b0;
    end else begin
      if (le_rise && state == FULL) rb <= shreg;
      else if (clk_acc)             rb <= rb >> 1;
      o_sdo <= rb[0];
    end
  end
`endif
endmodule

// File: tb/tb_atten_serial_rx.sv
// Randomized self-checking bench for atten_serial_rx against a frame-level model.
module tb_atten_serial_rx;
  localparam int DW = 8;
  localparam int TO = 1024;
  localparam int CW = 4;

  logic          i_clk = 1'b0;
  logic          i_reset, i_ser_clk, i_ser_data, i_le;
  logic [DW-1:0] o_data;
  logic          o_valid, o_frame_err, o_busy;
  logic [CW-1:0] o_good_count;
`ifdef ATTEN_RX_READBACK_EN
  logic          o_sdo;
`endif

  int n_cmp = 0, n_bad = 0;
  bit q[$];
  logic [DW-1:0] mdl_data;
  logic [CW-1:0] mdl_cnt;
  int exp_nv = 0, exp_ne = 0, mon_nv = 0, mon_ne = 0;
  bit le_held = 0;

  always #5 i_clk = ~i_clk;

  atten_serial_rx #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_ser_clk    (i_ser_clk),
    .i_ser_data   (i_ser_data),
    .i_le         (i_le),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_frame_err  (o_frame_err),
    .o_busy       (o_busy),
    .o_good_count (o_good_count)
`ifdef ATTEN_RX_READBACK_EN
    ,
    .o_sdo        (o_sdo)
`endif
  );

  always @(negedge i_clk) begin
    if (o_valid === 1'b1) mon_nv++;
    if (o_frame_err === 1'b1) mon_ne++;
  end

  function automatic logic [DW-1:0] assemble();
    logic [DW-1:0] v = '0;
    for (int i = 0; i < DW; i++) v[i] = q[i];
    return v;
  endfunction

  task automatic ser_bit(input logic b);
    @(negedge i_clk);
    i_ser_data = b;
    i_ser_clk  = 1'b0;
    repeat (4) @(negedge i_clk);
    i_ser_clk = 1'b1;
    repeat (4) @(negedge i_clk);
    i_ser_clk = 1'b0;
    if (!le_held) q.push_back(b);
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    for (int i = 0; i < DW; i++) ser_bit(w[i]);
  endtask

  task automatic pulse_le(input string nm, input bit clk_too);
    bit good;
    int nv, ne, cyc;
    logic [11:0] obs, exp;
    good = (q.size() == DW);
    if (good) begin
      mdl_data = assemble();
      mdl_cnt  = mdl_cnt + 1'b1;
      exp_nv++;
    end else begin
      exp_ne++;
    end
    q.delete();
    @(negedge i_clk);
    if (clk_too) begin
      i_ser_data = 1'($urandom);
      i_ser_clk  = 1'b0;
      repeat (4) @(negedge i_clk);
      i_ser_clk = 1'b1;
    end
    i_le = 1'b1;
    nv = 0; ne = 0; cyc = 0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge i_clk); #1;
      if (o_valid === 1'b1) begin nv++; cyc = c; end
      if (o_frame_err === 1'b1) begin ne++; cyc = c; end
    end
    obs = {nv[3:0], ne[3:0], cyc[3:0]};
    exp = {good ? 4'd1 : 4'd0, good ? 4'd0 : 4'd1, 4'd3};
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s strobes: got valid=%0d err=%0d at cycle %0d, want valid=%0d err=%0d at cycle 3",
               nm, nv, ne, cyc, good, !good);
    end
    n_cmp++;
    if (o_data !== mdl_data) begin
      n_bad++;
      $display("FAIL %s data: got %h want %h", nm, o_data, mdl_data);
    end
    n_cmp++;
    if (o_good_count !== mdl_cnt) begin
      n_bad++;
      $display("FAIL %s good_count: got %0d want %0d", nm, o_good_count, mdl_cnt);
    end
    n_cmp++;
    if (o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s busy: got %b want 0", nm, o_busy);
    end
    @(negedge i_clk);
    i_le      = 1'b0;
    i_ser_clk = 1'b0;
    repeat (4) @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_ser_clk = 1'b0; i_ser_data = 1'b0; i_le = 1'b0;
    mdl_data = '0; mdl_cnt = '0;
    repeat (3) @(negedge i_clk);
    n_cmp++;
    if ({o_data, o_valid, o_frame_err, o_busy, o_good_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got data=%h v=%b e=%b busy=%b cnt=%0d want all 0",
               o_data, o_valid, o_frame_err, o_busy, o_good_count);
    end
    i_reset = 1'b0;
    repeat (3) @(negedge i_clk);
  endtask

  task automatic test_basic();
    send_word(8'hA5);
    pulse_le("word_a5", 0);
  endtask

  task automatic test_short_long();
    for (int i = 0; i < DW - 1; i++) ser_bit(1'($urandom));
    pulse_le("short7", 0);
    for (int i = 0; i < DW + 1; i++) ser_bit(1'($urandom));
    pulse_le("long9", 0);
  endtask

  task automatic test_timeout();
    int errc = -1, nerr = 0;
    logic busy0, busy1;
    for (int i = 0; i < 4; i++) ser_bit(1'($urandom));
    busy0 = o_busy;
    for (int c = 1; c <= TO + 40; c++) begin
      @(posedge i_clk); #1;
      if (o_frame_err === 1'b1) begin
        nerr++;
        if (errc < 0) errc = c;
      end
    end
    busy1 = o_busy;
    q.delete();
    exp_ne++;
    n_cmp++;
    if (busy0 !== 1'b1) begin n_bad++; $display("FAIL timeout busy_before: got %b want 1", busy0); end
    n_cmp++;
    if (nerr != 1 || errc < TO - 8 || errc > TO + 4) begin
      n_bad++;
      $display("FAIL timeout err: got %0d pulses first at %0d, want 1 near cycle %0d", nerr, errc, TO);
    end
    n_cmp++;
    if (busy1 !== 1'b0) begin n_bad++; $display("FAIL timeout busy_after: got %b want 0", busy1); end
    send_word(8'h3C);
    pulse_le("after_timeout_3c", 0);
  endtask

  task automatic test_simul();
    for (int i = 0; i < DW - 1; i++) ser_bit(1'($urandom));
    pulse_le("clk_le_same_cycle", 1);
  endtask

  task automatic test_le_hold();
    @(negedge i_clk);
    i_le = 1'b1;
    exp_ne++;
    le_held = 1;
    repeat (6) @(negedge i_clk);
    for (int i = 0; i < 3; i++) ser_bit(1'($urandom));
    le_held = 0;
    i_le = 1'b0;
    repeat (4) @(negedge i_clk);
    send_word(8'($urandom));
    pulse_le("le_hold_then_word", 0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) ser_bit(1'($urandom));
    @(negedge i_clk);
    #2 i_reset = 1'b1;
    #1;
    q.delete();
    mdl_data = '0;
    mdl_cnt  = '0;
    n_cmp++;
    if ({o_data, o_valid, o_frame_err, o_busy, o_good_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: got data=%h v=%b e=%b busy=%b cnt=%0d want all 0",
               o_data, o_valid, o_frame_err, o_busy, o_good_count);
    end
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    repeat (3) @(negedge i_clk);
    send_word(8'hFF);
    pulse_le("after_reset_ff", 0);
  endtask

  task automatic test_random();
    int n;
    for (int f = 0; f < 28; f++) begin
      n = ($urandom_range(0, 3) != 0) ? DW : int'($urandom_range(0, DW + 2));
      for (int i = 0; i < n; i++) ser_bit(1'($urandom));
      pulse_le($sformatf("rand%0d_len%0d", f, n), 0);
    end
  endtask

`ifdef ATTEN_RX_READBACK_EN
  task automatic test_readback();
    logic [DW-1:0] latched, obs;
    logic b;
    send_word(8'h81);
    pulse_le("rb_latch_81", 0);
    latched = mdl_data;
    for (int i = 0; i < DW; i++) begin
      b = 1'($urandom);
      @(negedge i_clk);
      i_ser_data = b;
      i_ser_clk  = 1'b0;
      repeat (4) @(negedge i_clk);
      obs[i] = o_sdo;
      i_ser_clk = 1'b1;
      repeat (4) @(negedge i_clk);
      i_ser_clk = 1'b0;
      q.push_back(b);
    end
    n_cmp++;
    if (obs !== latched) begin
      n_bad++;
      $display("FAIL readback sdo sequence (bit i = i-th sample): got %b want %b", obs, latched);
    end
    pulse_le("rb_close", 0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_short_long();
    test_timeout();
    test_simul();
    test_le_hold();
    test_reset_mid();
    test_random();
`ifdef ATTEN_RX_READBACK_EN
    test_readback();
`endif
    repeat (5) @(negedge i_clk);
    n_cmp++;
    if (mon_nv != exp_nv) begin
      n_bad++;
      $display("FAIL total_valid: got %0d pulses want %0d", mon_nv, exp_nv);
    end
    n_cmp++;
    if (mon_ne != exp_ne) begin
      n_bad++;
      $display("FAIL total_frame_err: got %0d pulses want %0d", mon_ne, exp_ne);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
